// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// A fetch entry pairs an instruction with the PC it was fetched from.
package fetch_unit_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through FIFO with synchronous clear.
// The head entry is visible combinationally whenever count is non-zero.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A full FIFO may still accept a push when the head is leaving in the same cycle.
    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
            if (do_push && !do_pop)
                count_reg <= count_reg + CW'(1);
            else if (!do_push && do_pop)
                count_reg <= count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Credit-limited instruction fetch with FWFT instruction buffer and redirect handling.
// Responses to requests issued before a redirect are counted off in drop_count and discarded.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   fetch_pc_reg;
    logic [31:0]   fetch_pc_next;
    logic [CW-1:0] drop_count_reg;
    logic [CW-1:0] drop_count_next;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [CW+1:0] credit_sum;
    logic          req_accept;
    logic          rsp_keep;
    logic [31:0]   pcq_head;
    fetch_entry_t  rsp_entry;
    fetch_entry_t  head_entry;

    assign credit_sum = (CW+2)'(outstanding) + (CW+2)'(fifo_count) + (CW+2)'(drop_count_reg);

    assign imem_req_valid = !reset && !redirect_valid && (credit_sum < (CW+2)'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign req_accept     = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && !redirect_valid && (drop_count_reg == '0);
    assign rsp_entry      = '{pc: pcq_head, instr: imem_rsp_data};

    // The request-PC queue occupancy is exactly the number of live (non-dropped) requests in flight.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_pc_queue (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (req_accept),
        .push_data (fetch_pc_reg),
        .pop       (rsp_keep),
        .head      (pcq_head),
        .count     (outstanding)
    );

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (rsp_keep),
        .push_data (rsp_entry),
        .pop       (if_valid && if_ready && !redirect_valid),
        .head      (head_entry),
        .count     (fifo_count)
    );

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid)
            fetch_pc_next = {redirect_pc[31:2], 2'b00};
        else if (req_accept)
            fetch_pc_next = fetch_pc_reg + 32'd4;
    end

    // Live requests become drop debt on redirect; a response in the redirect cycle pays one off.
    always_comb begin
        drop_count_next = drop_count_reg;
        if (redirect_valid) begin
            drop_count_next = drop_count_reg + outstanding;
            if (imem_rsp_valid && (drop_count_next != '0))
                drop_count_next = drop_count_next - CW'(1);
        end else if (imem_rsp_valid && (drop_count_reg != '0)) begin
            drop_count_next = drop_count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg   <= RESET_PC;
            drop_count_reg <= '0;
        end else begin
            fetch_pc_reg   <= fetch_pc_next;
            drop_count_reg <= drop_count_next;
        end
    end

    assign if_valid = !reset && (fifo_count != '0);
    assign if_pc    = if_valid ? head_entry.pc    : 32'h0;
    assign if_instr = if_valid ? head_entry.instr : NOP;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a simple in-order memory model.
// Each scenario task drives inputs on the falling edge and checks outputs shortly after.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        mem_en;
    logic [31:0] mem_q[$];
    logic [31:0] exp_pc;
    int          errors = 0;
    int          checks = 0;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr ^ 32'hA5C3_0F00;
    endfunction

    // In-order memory: one-cycle latency while mem_en is high, otherwise requests queue up.
    always @(posedge clk) begin
        if (reset) begin
            mem_q.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
            if (mem_en && mem_q.size() != 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= instr_of(mem_q.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b1; mem_en = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got=%b exp=0", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got=%h exp=0", if_pc); end
        checks++; if (if_instr !== NOP) begin errors++; $display("FAIL reset_if_instr got=%h exp=%h", if_instr, NOP); end
        $display("reset: req_valid=%b if_valid=%b if_pc=%h if_instr=%h", imem_req_valid, if_valid, if_pc, if_instr);
    endtask

    task automatic test_stream();
        @(negedge clk);
        reset = 1'b0; mem_en = 1'b1;
        exp_pc = RPC;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC + 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_req[%0d] got=%b/%h exp=1/%h", i, imem_req_valid, imem_req_addr, RPC + 32'(4 * i));
            end
            if (i >= 2) begin
                checks++;
                if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== instr_of(exp_pc)) begin
                    errors++;
                    $display("FAIL stream_if[%0d] got=%b/%h/%h exp=1/%h/%h", i, if_valid, if_pc, if_instr, exp_pc, instr_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            $display("stream cycle %0d: req=%b addr=%h if_valid=%b if_pc=%h", i, imem_req_valid, imem_req_addr, if_valid, if_pc);
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int n;
        if_ready = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid); end
        checks++;
        if (if_valid !== 1'b1 || if_pc !== exp_pc) begin
            errors++; $display("FAIL stall_head got=%b/%h exp=1/%h", if_valid, if_pc, exp_pc);
        end
        $display("stall: req_valid=%b head=%h", imem_req_valid, if_pc);
        imem_req_ready = 1'b0; if_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (if_valid) begin
                checks++;
                if (if_pc !== exp_pc || if_instr !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL drain_pop got=%h/%h exp=%h/%h", if_pc, if_instr, exp_pc, instr_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
            @(negedge clk);
        end
        checks++; if (n != DEPTH) begin errors++; $display("FAIL buffered_count got=%0d exp=%0d", n, DEPTH); end
        $display("drain: popped %0d entries", n);
        imem_req_ready = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
            errors++; $display("FAIL resume_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, exp_pc);
        end
        n = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (if_valid) begin
                checks++;
                if (if_pc !== exp_pc || if_instr !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL resume_pop got=%h/%h exp=%h/%h", if_pc, if_instr, exp_pc, instr_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
        end
        checks++; if (n < 4) begin errors++; $display("FAIL resume_count got=%0d exp>=4", n); end
        $display("resume: popped %0d entries, next pc %h", n, exp_pc);
    endtask

    task automatic test_redirect();
        int got;
        @(negedge clk);
        reset = 1'b1; imem_req_ready = 1'b0; mem_en = 1'b0; if_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h10;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redirect_blocks_req got=%b exp=0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin errors++; $display("FAIL old_req0 got=%b/%h exp=1/00000010", imem_req_valid, imem_req_addr); end
        @(negedge clk); #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h14) begin errors++; $display("FAIL old_req1 got=%b/%h exp=1/00000014", imem_req_valid, imem_req_addr); end
        @(negedge clk);
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0; imem_req_ready = 1'b1; mem_en = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL new_req got=%b/%h exp=1/00000200", imem_req_valid, imem_req_addr); end
        exp_pc = 32'h200;
        got = 0;
        for (int c = 0; c < 12 && got < 2; c++) begin
            if (if_valid) begin
                checks++;
                if (if_pc !== exp_pc || if_instr !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL redirect_pop got=%h/%h exp=%h/%h", if_pc, if_instr, exp_pc, instr_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            @(negedge clk); #1;
        end
        checks++; if (got != 2) begin errors++; $display("FAIL redirect_timeout got=%0d exp=2", got); end
        $display("redirect to 200: first pops checked=%0d", got);
    endtask

    task automatic test_redirect_rsp();
        int n;
        int got;
        @(negedge clk);
        mem_en = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL prefill got=%b/%b exp=0/0", imem_req_valid, if_valid);
        end
        mem_en = 1'b1; imem_req_ready = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h300; mem_en = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== NOP) begin
            errors++; $display("FAIL fifo_empty_after_redirect got=%b/%h exp=0/%h", if_valid, if_instr, NOP);
        end
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (imem_req_valid) begin
                checks++;
                if (imem_req_addr !== 32'h300 + 32'(4 * n)) begin
                    errors++; $display("FAIL post_redirect_addr got=%h exp=%h", imem_req_addr, 32'h300 + 32'(4 * n));
                end
                n++;
            end
            @(negedge clk); #1;
        end
        checks++; if (n != DEPTH - 3) begin errors++; $display("FAIL drop_credits got=%0d exp=%0d", n, DEPTH - 3); end
        $display("redirect with rsp: requests issued under drop debt=%0d", n);
        mem_en = 1'b1;
        got = 0;
        for (int c = 0; c < 12 && got == 0; c++) begin
            @(negedge clk); #1;
            if (if_valid) begin
                checks++;
                if (if_pc !== 32'h300 || if_instr !== instr_of(32'h300)) begin
                    errors++; $display("FAIL first_after_drop got=%h/%h exp=00000300/%h", if_pc, if_instr, instr_of(32'h300));
                end
                got++;
            end
        end
        checks++; if (got != 1) begin errors++; $display("FAIL drop_timeout got=%0d exp=1", got); end
    endtask

    task automatic test_wrap();
        int got;
        @(negedge clk);
        reset = 1'b1; mem_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        imem_req_ready = 1'b1; if_ready = 1'b1; mem_en = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0 got=%b/%h exp=1/fffffffc", imem_req_valid, imem_req_addr); end
        @(negedge clk); #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_req1 got=%b/%h exp=1/00000000", imem_req_valid, imem_req_addr); end
        exp_pc = 32'hFFFF_FFFC;
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            if (if_valid) begin
                checks++;
                if (if_pc !== exp_pc || if_instr !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL wrap_pop got=%h/%h exp=%h/%h", if_pc, if_instr, exp_pc, instr_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            @(negedge clk); #1;
        end
        checks++; if (got != 2) begin errors++; $display("FAIL wrap_timeout got=%0d exp=2", got); end
        $display("wrap: pops checked=%0d next pc %h", got, exp_pc);
    endtask

    task automatic test_reset_mid();
        int got;
        @(negedge clk);
        if_ready = 1'b0; mem_en = 1'b1; imem_req_ready = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (if_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL full_before_reset got=%b/%b exp=1/0", if_valid, imem_req_valid);
        end
        reset = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (if_valid !== 1'b0 || if_instr !== NOP || if_pc !== 32'h0 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got=%b/%h/%h/%b exp=0/%h/0/0", if_valid, if_instr, if_pc, imem_req_valid, NOP);
        end
        reset = 1'b0; if_ready = 1'b1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin errors++; $display("FAIL first_req_after_reset got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RPC); end
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk); #1;
            if (if_valid) begin
                checks++;
                if (if_pc !== RPC || if_instr !== instr_of(RPC)) begin
                    errors++; $display("FAIL first_if_after_reset got=%h/%h exp=%h/%h", if_pc, if_instr, RPC, instr_of(RPC));
                end
                got++;
            end
        end
        checks++; if (got != 1) begin errors++; $display("FAIL reset_mid_timeout got=%0d exp=1", got); end
        $display("mid-operation reset: restart at %h", RPC);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_rsp();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
